// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Video mode constants and width helpers for the display timing path.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Current 200-column x 600-line mode (264 x 628 pixel clocks per frame)
    localparam int c_def_h_vis   = 200;
    localparam int c_def_h_fp    = 10;
    localparam int c_def_h_sync  = 32;
    localparam int c_def_h_bp    = 22;
    localparam int c_def_v_vis   = 600;
    localparam int c_def_v_fp    = 1;
    localparam int c_def_v_sync  = 4;
    localparam int c_def_v_bp    = 23;
    localparam bit c_def_h_pol   = 1'b1;
    localparam bit c_def_v_pol   = 1'b1;
    localparam int c_def_clk_div = 1;
    localparam int c_def_y_shift = 2;
    localparam int c_def_cw      = 2;
    localparam int c_def_pipe    = 1;

    // Industry 640x480 mode, negative syncs
    localparam int c_vga_h_vis  = 640;
    localparam int c_vga_h_fp   = 16;
    localparam int c_vga_h_sync = 96;
    localparam int c_vga_h_bp   = 48;
    localparam int c_vga_v_vis  = 480;
    localparam int c_vga_v_fp   = 10;
    localparam int c_vga_v_sync = 2;
    localparam int c_vga_v_bp   = 33;
    localparam bit c_vga_h_pol  = 1'b0;
    localparam bit c_vga_v_pol  = 1'b0;

    // Active sits in the LSB so a one-bit tap of the delay line picks it out.
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } sync_bits_t;

    function automatic int clog2_safe(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    function automatic int mode_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int c_def_h_total = mode_total(c_def_h_vis, c_def_h_fp, c_def_h_sync, c_def_h_bp);
    localparam int c_def_v_total = mode_total(c_def_v_vis, c_def_v_fp, c_def_v_sync, c_def_v_bp);

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : sync_delay_line
// Brief    : Enabled shift register with async active-low clear and a low-bit tap.
// Revision : 1.0 - initial release
// ============================================================================
module sync_delay_line #(
    parameter int WIDTH     = 3,
    parameter int DEPTH     = 2,
    parameter int TAP_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [WIDTH-1:0]     i_data,
    output logic [TAP_WIDTH-1:0] o_tap,
    output logic [WIDTH-1:0]     o_data
);

    if (DEPTH < 1 || TAP_WIDTH < 1 || TAP_WIDTH > WIDTH) begin : g_bad_shape
        $error("sync_delay_line: DEPTH must be >= 1 and TAP_WIDTH within 1..WIDTH");
    end

    logic [DEPTH-1:0][WIDTH-1:0] r_stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] w_stage_d;

    always_comb begin
        w_stage_d = r_stage_q;
        if (i_en) begin
            w_stage_d[0] = i_data;
            for (int i = 1; i < DEPTH; i++) begin
                w_stage_d[i] = r_stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage_q <= '0;
        end else begin
            r_stage_q <= w_stage_d;
        end
    end

    assign o_data = r_stage_q[DEPTH-1];

    // The tap is the value that enters the last stage on the next enable.
    if (DEPTH == 1) begin : g_tap_input
        assign o_tap = i_data[TAP_WIDTH-1:0];
    end else begin : g_tap_stage
        assign o_tap = r_stage_q[DEPTH-2][TAP_WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised video timing, sync alignment and colour blanking stage.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS    = c_def_h_vis,
    parameter int H_FP     = c_def_h_fp,
    parameter int H_SYNC   = c_def_h_sync,
    parameter int H_BP     = c_def_h_bp,
    parameter int V_VIS    = c_def_v_vis,
    parameter int V_FP     = c_def_v_fp,
    parameter int V_SYNC   = c_def_v_sync,
    parameter int V_BP     = c_def_v_bp,
    parameter bit H_POL    = c_def_h_pol,
    parameter bit V_POL    = c_def_v_pol,
    parameter int CLK_DIV  = c_def_clk_div,
    parameter int Y_SHIFT  = c_def_y_shift,
    parameter int CW       = c_def_cw,
    parameter int PIPE_LAT = c_def_pipe
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [3*CW-1:0]                      rgb_in,
    output logic [clog2_safe(H_VIS)-1:0]         x_out,
    output logic [clog2_safe(V_VIS)-Y_SHIFT-1:0] y_out,
    output logic                                 active,
    output logic                                 pix_en,
    output logic                                 frame_start,
    output logic                                 line_end,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic [CW-1:0]                        r,
    output logic [CW-1:0]                        g,
    output logic [CW-1:0]                        b
);

    localparam int c_h_total = mode_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = mode_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int c_dw      = clog2_safe(CLK_DIV);
    localparam int c_hw      = clog2_safe(c_h_total);
    localparam int c_vw      = clog2_safe(c_v_total);
    localparam int c_xw      = clog2_safe(H_VIS);
    localparam int c_yw      = clog2_safe(V_VIS) - Y_SHIFT;

    localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
    localparam logic [c_hw-1:0] c_h_last   = c_hw'(c_h_total - 1);
    localparam logic [c_hw-1:0] c_h_vis    = c_hw'(H_VIS);
    localparam logic [c_hw-1:0] c_hs_start = c_hw'(H_VIS + H_FP);
    localparam logic [c_hw-1:0] c_hs_end   = c_hw'(H_VIS + H_FP + H_SYNC);
    localparam logic [c_vw-1:0] c_v_last   = c_vw'(c_v_total - 1);
    localparam logic [c_vw-1:0] c_v_vis    = c_vw'(V_VIS);
    localparam logic [c_vw-1:0] c_vs_start = c_vw'(V_VIS + V_FP);
    localparam logic [c_vw-1:0] c_vs_end   = c_vw'(V_VIS + V_FP + V_SYNC);

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1
        || CLK_DIV < 1) begin : g_bad_timing
        $error("vga_timing_gen: porch/sync widths and CLK_DIV must all be >= 1");
    end
    if (Y_SHIFT < 0 || Y_SHIFT >= clog2_safe(V_VIS)) begin : g_bad_yshift
        $error("vga_timing_gen: Y_SHIFT must be below clog2(V_VIS)");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE_LAT must be within 0..7");
    end

    logic [c_dw-1:0] r_div_cnt_q, w_div_cnt_d;
    logic            r_pix_en_q,  w_pix_en_d;
    logic            r_run_q,     w_run_d;
    logic [c_hw-1:0] r_h_cnt_q,   w_h_cnt_d;
    logic [c_vw-1:0] r_v_cnt_q,   w_v_cnt_d;
    logic [3*CW-1:0] r_rgb_q,     w_rgb_d;

    logic            w_h_last;
    logic            w_v_last;
    logic            w_live;
    logic            w_hs_raw;
    logic            w_vs_raw;
    logic            w_gate_active;
    sync_bits_t      w_raw;
    sync_bits_t      w_final;

    assign w_h_last = (r_h_cnt_q == c_h_last);
    assign w_v_last = (r_v_cnt_q == c_v_last);

    // pix_en is registered so it is low in reset and first rises CLK_DIV clocks after release.
    always_comb begin
        w_div_cnt_d = (r_div_cnt_q == c_div_last) ? '0 : r_div_cnt_q + 1'b1;
        w_pix_en_d  = (r_div_cnt_q == c_div_last);
        w_run_d     = r_run_q | r_pix_en_q;
        w_h_cnt_d   = r_h_cnt_q;
        w_v_cnt_d   = r_v_cnt_q;
        if (r_pix_en_q) begin
            if (w_h_last) begin
                w_h_cnt_d = '0;
                w_v_cnt_d = w_v_last ? '0 : r_v_cnt_q + 1'b1;
            end else begin
                w_h_cnt_d = r_h_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        w_rgb_d = r_rgb_q;
        if (r_pix_en_q) begin
            w_rgb_d = w_gate_active ? rgb_in : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt_q <= '0;
            r_pix_en_q  <= 1'b0;
            r_run_q     <= 1'b0;
            r_h_cnt_q   <= '0;
            r_v_cnt_q   <= '0;
            r_rgb_q     <= '0;
        end else begin
            r_div_cnt_q <= w_div_cnt_d;
            r_pix_en_q  <= w_pix_en_d;
            r_run_q     <= w_run_d;
            r_h_cnt_q   <= w_h_cnt_d;
            r_v_cnt_q   <= w_v_cnt_d;
            r_rgb_q     <= w_rgb_d;
        end
    end

    // Counters sit at (0,0) in reset; active stays low until the first pixel strobe.
    assign w_live   = r_run_q | r_pix_en_q;
    assign active   = w_live && (r_h_cnt_q < c_h_vis) && (r_v_cnt_q < c_v_vis);
    assign w_hs_raw = (r_h_cnt_q >= c_hs_start) && (r_h_cnt_q < c_hs_end);
    assign w_vs_raw = (r_v_cnt_q >= c_vs_start) && (r_v_cnt_q < c_vs_end);

    assign x_out       = active ? c_xw'(r_h_cnt_q) : '0;
    assign y_out       = active ? c_yw'(r_v_cnt_q >> Y_SHIFT) : '0;
    assign pix_en      = r_pix_en_q;
    assign frame_start = r_pix_en_q && (r_h_cnt_q == '0) && (r_v_cnt_q == '0);
    assign line_end    = r_pix_en_q && w_h_last;

    assign w_raw = {w_hs_raw, w_vs_raw, active};

    sync_delay_line #(
        .WIDTH     ($bits(sync_bits_t)),
        .DEPTH     (PIPE_LAT + 1),
        .TAP_WIDTH (1)
    ) u_sync_delay (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_pix_en_q),
        .i_data (w_raw),
        .o_tap  (w_gate_active),
        .o_data (w_final)
    );

    assign hsync = w_final.hs ? H_POL : ~H_POL;
    assign vsync = w_final.vs ? V_POL : ~V_POL;

    // Colour and final active describe the same pixel; masking again keeps blanking exact.
    assign {r, g, b} = w_final.active ? r_rgb_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for vga_timing_gen on a small 15x12 mode, CLK_DIV=2, PIPE_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int c_h_vis  = 8;
    localparam int c_h_fp   = 2;
    localparam int c_h_sync = 3;
    localparam int c_h_bp   = 2;
    localparam int c_v_vis  = 8;
    localparam int c_v_fp   = 1;
    localparam int c_v_sync = 2;
    localparam int c_v_bp   = 1;
    localparam int c_h_tot  = 15;
    localparam int c_v_tot  = 12;
    localparam int c_div    = 2;
    localparam int c_lat    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] rgb_in = 6'h3F;

    logic [2:0] w_x;
    logic [1:0] w_y;
    logic       w_active, w_pix_en, w_frame_start, w_line_end, w_hsync, w_vsync;
    logic [1:0] w_r, w_g, w_b;

    typedef struct packed {
        logic       pe;
        logic [2:0] x;
        logic [1:0] y;
        logic       act;
        logic       fs;
        logic       le;
        logic       hs;
        logic       vs;
        logic [5:0] rgb;
    } obs_t;

    obs_t sb[$];
    int   sb_id[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    bit   running = 1'b0;

    vga_timing_gen #(
        .H_VIS(c_h_vis), .H_FP(c_h_fp), .H_SYNC(c_h_sync), .H_BP(c_h_bp),
        .V_VIS(c_v_vis), .V_FP(c_v_fp), .V_SYNC(c_v_sync), .V_BP(c_v_bp),
        .H_POL(1'b1), .V_POL(1'b0), .CLK_DIV(c_div), .Y_SHIFT(1), .CW(2), .PIPE_LAT(c_lat)
    ) dut (
        .clk(clk), .rst(rst), .rgb_in(rgb_in),
        .x_out(w_x), .y_out(w_y), .active(w_active), .pix_en(w_pix_en),
        .frame_start(w_frame_start), .line_end(w_line_end),
        .hsync(w_hsync), .vsync(w_vsync), .r(w_r), .g(w_g), .b(w_b)
    );

    always #50 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test after 1 ms, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [5:0] colour(input int q);
        return 6'((q * 13 + 7) % 64);
    endfunction

    // hsync active-high, vsync active-low; sync and colour lag the counters by 4 pixels.
    function automatic obs_t expect_px(input int p);
        obs_t e;
        int h, v, q, hq, vq;
        h = p % c_h_tot;
        v = (p / c_h_tot) % c_v_tot;
        e.pe  = 1'b1;
        e.act = (h < c_h_vis) && (v < c_v_vis);
        e.x   = e.act ? 3'(h) : 3'd0;
        e.y   = e.act ? 2'(v / 2) : 2'd0;
        e.fs  = (h == 0) && (v == 0);
        e.le  = (h == c_h_tot - 1);
        q = p - (c_lat + 1);
        if (q < 0) begin
            e.hs  = 1'b0;
            e.vs  = 1'b1;
            e.rgb = 6'd0;
        end else begin
            hq = q % c_h_tot;
            vq = (q / c_h_tot) % c_v_tot;
            e.hs  = (hq >= 10) && (hq < 13);
            e.vs  = !((vq >= 9) && (vq < 11));
            e.rgb = ((hq < c_h_vis) && (vq < c_v_vis)) ? colour(q) : 6'd0;
        end
        return e;
    endfunction

    function automatic obs_t rst_obs();
        obs_t e;
        e = {1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0};
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = {w_pix_en, w_x, w_y, w_active, w_frame_start, w_line_end, w_hsync, w_vsync, w_r, w_g, w_b};
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("pe=%b x=%0d y=%0d act=%b fs=%b le=%b hs=%b vs=%b rgb=%h",
                         o.pe, o.x, o.y, o.act, o.fs, o.le, o.hs, o.vs, o.rgb);
    endfunction

    task automatic compare(input string name, input obs_t got, input obs_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %s, want %s", name, fmt(got), fmt(want));
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        int   id;
        if (running && rst && w_pix_en) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pix_en: got pix_en=1 at %0t, want no pixel slot", $time);
            end else begin
                e  = sb.pop_front();
                id = sb_id.pop_front();
                compare($sformatf("pixel_%0d", id), observe(), e);
            end
        end
    end

    task automatic run_pixels(input int n);
        for (int p = 0; p < n; p++) begin
            repeat (c_div) @(posedge clk);
            #1;
            rgb_in = (p < c_lat) ? 6'h3F : colour(p - c_lat);
            sb.push_back(expect_px(p));
            sb_id.push_back(p);
        end
    endtask

    task automatic drain_check(input string name);
        @(negedge clk);
        #1;
        running = 1'b0;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d unconsumed pixel slots, want 0", name, sb.size());
            sb.delete();
            sb_id.delete();
        end
    endtask

    initial begin
        rst    = 1'b0;
        rgb_in = 6'h3F;
        repeat (10) @(negedge clk);
        compare("reset_hold", observe(), rst_obs());

        rst     = 1'b1;
        running = 1'b1;
        run_pixels(230);
        drain_check("drain_first_run");

        @(posedge clk);
        #3 rst = 1'b0;
        #1 compare("async_reset_midframe", observe(), rst_obs());
        repeat (5) @(negedge clk);
        compare("reset_held_again", observe(), rst_obs());

        rgb_in  = 6'h3F;
        rst     = 1'b1;
        running = 1'b1;
        run_pixels(200);
        drain_check("drain_second_run");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
